afe_frame_sequencer: RTL

//  Frame-level scheduler for the AFE line-timing engine. Sequences N line cycles per frame.
//  Per line: issues a one-cycle start, waits for the engine's done, then applies a programmable inter-line gap.

---
 rtl/afe_seq_pkg.sv | 28 ++
 rtl/afe_seq_timer.sv | 50 +++++
 rtl/afe_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/afe_seq_pkg.sv
// -----------------------------------------------------------------------------
// afe_seq_pkg
// Shared definitions for the AFE frame sequencer:
//   - default widths for line count, inter-line gap and integration word
//   - default watchdog limit in CLK_100M cycles
//   - 3-bit FSM state encoding
//   - small helper used to size the shared gap/watchdog timer
// -----------------------------------------------------------------------------
package afe_seq_pkg;

  localparam int unsigned LINE_W_DEF      = 12;
  localparam int unsigned GAP_W_DEF       = 16;
  localparam int unsigned INTG_W_DEF      = 12;
  localparam int unsigned TIMEOUT_CYC_DEF = 4000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/afe_seq_timer.sv
// -----------------------------------------------------------------------------
// afe_seq_timer
// Loadable down-counter shared by the inter-line gap and the line watchdog.
// Load has priority over decrement; the count holds at zero.
// Ports:
//   CLK_100M  in   system clock
//   CLK_RST   in   asynchronous reset, active-high
//   load      in   load load_val this cycle
//   load_val  in   W-bit value to load
//   en        in   decrement by one (ignored while load is high or at zero)
//   zero      out  count is zero
// -----------------------------------------------------------------------------
module afe_seq_timer
  import afe_seq_pkg::*;
#(
  parameter int unsigned W = GAP_W_DEF
) (
  input  logic         CLK_100M,
  input  logic         CLK_RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: assign a default before any branch so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/afe_frame_sequencer.sv
// -----------------------------------------------------------------------------
// afe_frame_sequencer
// Frame-level scheduler for the AFE line-timing engine. On an accepted trigger
// it latches the frame configuration, then for each of cfg_lines lines issues a
// one-cycle line_start, waits for line_done and idles for cfg_gap cycles.
//
// Build option:
//   AFE_SEQ_TIMEOUT_EN  when defined, a watchdog aborts the frame if line_done
//                       does not arrive within TIMEOUT_CYC cycles of line_start
//                       (err_timeout pulse). Otherwise err_timeout is tied 0.
//
// Ports:
//   CLK_100M     in   system clock, 100 MHz
//   CLK_RST      in   asynchronous reset, active-high
//   ADS_INIT_OK  in   ADC init complete; frames accepted only while high
//   frame_trig   in   frame request, sampled in IDLE
//   cfg_lines    in   lines per frame (0 rejects the trigger)
//   cfg_gap      in   idle cycles between line_done and next line_start
//   cfg_intg     in   integration word for the frame
//   line_start   out  one-cycle pulse starting an AFE line
//   line_done    in   one-cycle pulse from the line engine
//   line_intg    out  integration word latched at frame load
//   row_idx      out  index of current line
//   frame_busy   out  high while a frame is in progress
//   frame_done   out  one-cycle pulse after the last line_done
//   err_timeout  out  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module afe_frame_sequencer
  import afe_seq_pkg::*;
#(
  parameter int unsigned LINE_W      = LINE_W_DEF,
  parameter int unsigned GAP_W       = GAP_W_DEF,
  parameter int unsigned INTG_W      = INTG_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLK_100M,
  input  logic              CLK_RST,
  input  logic              ADS_INIT_OK,
  input  logic              frame_trig,
  input  logic [LINE_W-1:0] cfg_lines,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [INTG_W-1:0] cfg_intg,
  output logic              line_start,
  input  logic              line_done,
  output logic [INTG_W-1:0] line_intg,
  output logic [LINE_W-1:0] row_idx,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              err_timeout
);

  // One timer serves both the gap and the watchdog, so it must hold either.
  localparam int unsigned TMR_W = max_u(GAP_W, $clog2(TIMEOUT_CYC));

  state_t            state_q, state_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [LINE_W-1:0] row_q,   row_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic [INTG_W-1:0] intg_q,  intg_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic              tmr_load;
  logic              tmr_en;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic              last_line;
  logic              gap_zero;
  logic              wd_expire;

  // Comparing against lines_q-1 stops row_q before it could wrap.
  assign last_line = (row_q == (lines_q - LINE_W'(1)));
  assign gap_zero  = (gap_q == '0);

`ifdef AFE_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  // A line_done arriving in the expiry cycle wins over the abort.
  assign wd_expire = (state_q == ST_WAIT) && !line_done && tmr_zero;
`else
  assign wd_expire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Shared timer
  // ---------------------------------------------------------------------------
  afe_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .CLK_100M (CLK_100M),
    .CLK_RST  (CLK_RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    // Loading gap-1 and leaving GAP on zero gives exactly gap_q GAP cycles.
    tmr_val  = TMR_W'(gap_q - GAP_W'(1));
    if ((state_q == ST_WAIT) && line_done && !last_line && ADS_INIT_OK && !gap_zero) begin
      tmr_load = 1'b1;
    end
    if (state_q == ST_GAP) begin
      tmr_en = 1'b1;
    end
`ifdef AFE_SEQ_TIMEOUT_EN
    // Loaded in START; reaching zero after TIMEOUT_CYC-1 WAIT cycles makes the
    // registered err_timeout land TIMEOUT_CYC cycles after line_start.
    if (state_q == ST_START) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(TIMEOUT_CYC - 2);
    end
    if (state_q == ST_WAIT) begin
      tmr_en = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ADS_INIT_OK && frame_trig && (cfg_lines != '0)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_START;
      // A line_done coinciding with START is deliberately not looked at.
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (line_done) begin
          // Losing ADC init lets the current line finish, then stops the frame.
          if (last_line || !ADS_INIT_OK) begin
            state_d = ST_IDLE;
          end else if (gap_zero) begin
            state_d = ST_START;
          end else begin
            state_d = ST_GAP;
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!ADS_INIT_OK) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame configuration latches, row counter and status flags
  // ---------------------------------------------------------------------------
  always_comb begin
    lines_d = lines_q;
    gap_d   = gap_q;
    intg_d  = intg_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        lines_d = cfg_lines;
        gap_d   = cfg_gap;
        intg_d  = cfg_intg;
        row_d   = '0;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        if (line_done) begin
          if (last_line) begin
            busy_d = 1'b0;
            // An init loss during the last line still suppresses frame_done.
            done_d = ADS_INIT_OK;
          end else if (!ADS_INIT_OK) begin
            busy_d = 1'b0;
          end else begin
            row_d = row_q + LINE_W'(1);
          end
        end else if (wd_expire) begin
          busy_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (!ADS_INIT_OK) begin
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      lines_q <= '0;
      gap_q   <= '0;
      intg_q  <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lines_q <= lines_d;
      gap_q   <= gap_d;
      intg_q  <= intg_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef AFE_SEQ_TIMEOUT_EN
  assign err_d = wd_expire;

  always_ff @(posedge CLK_100M or posedge CLK_RST) begin
    if (CLK_RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    line_start  = (state_q == ST_START);
    line_intg   = intg_q;
    row_idx     = row_q;
    frame_busy  = busy_q;
    frame_done  = done_q;
`ifdef AFE_SEQ_TIMEOUT_EN
    err_timeout = err_q;
`else
    err_timeout = 1'b0;
`endif
  end

endmodule
